// File: rtl/sha256d_pkg.sv
// ---------------------------------------------------------------------------
// sha256d_pkg
// Shared definitions for the SHA-256d nonce scheduler:
//   - sched_state_e : scheduler FSM encoding (also driven out for debug)
//   - HDR_WORDS     : number of 32-bit header words (80-byte block header)
//   - TGT_BASE      : first host address of the target words (MS word first)
//   - NEND_ADDR     : host address of the nonce_end register
//   - bswap256()    : full 256-bit byte reversal (byte 0 becomes the MS byte)
// ---------------------------------------------------------------------------
package sha256d_pkg;

  localparam int HDR_WORDS = 20;
  localparam int TGT_BASE  = 20;
  localparam int TGT_WORDS = 8;
  localparam int NEND_ADDR = 28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_HASH   = 2'd2,
    ST_CHECK  = 2'd3
  } sched_state_e;

  // The hasher emits its digest in little-endian byte order; the comparison
  // against the target needs the big-endian numeric value.
  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = x[8*(31-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256d_target_cmp.sv
// ---------------------------------------------------------------------------
// sha256d_target_cmp
// Combinational 256-bit unsigned "value <= target" compare.
// Ports:
//   value  in  256 : byte-reversed double hash (numeric value)
//   target in  256 : difficulty target (numeric value)
//   le     out 1   : value <= target
// ---------------------------------------------------------------------------
module sha256d_target_cmp (
  input  logic [255:0] value,
  input  logic [255:0] target,
  output logic         le
);

  assign le = (value <= target);

endmodule

// File: rtl/sha256d_nonce_scheduler.sv
// ---------------------------------------------------------------------------
// sha256d_nonce_scheduler
// Job controller that drives sha256d_wrapper through a nonce search over one
// 80-byte block header. Holds the header, the 256-bit target and nonce_end,
// serves the hasher's word requests (substituting the live nonce at
// NONCE_WORD), checks each double hash against the target and steps the nonce
// until a hit, range exhaustion or a host stop.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   cfg_we/cfg_addr/wdata  : host writes (0-19 header, 20-27 target MS first,
//                            28 nonce_end); accepted only while idle
//   go, stop               : start / abort pulses
//   h_start                : one-cycle start pulse to the hasher
//   h_addr/h_rq            : hasher word request
//   h_data/h_rdy           : registered word response
//   h_hash/h_done          : hasher result and completion pulse
//   busy, found, exhausted : job status (found/exhausted sticky per job)
//   found_nonce            : nonce that produced the hit
//   hash_count             : hashes completed this job (saturating)
//   state_dbg              : current FSM state
//
// Word-request handshake: the hasher raises h_rq with h_addr for one or more
// cycles; every cycle h_rq is sampled high in HASH produces exactly one h_rdy
// pulse on the following cycle with h_data holding the answer. h_data then
// stays unchanged until the next request is answered. No backpressure.
// ---------------------------------------------------------------------------
module sha256d_nonce_scheduler
  import sha256d_pkg::*;
#(
  parameter int NONCE_WORD = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [4:0]   cfg_addr,
  input  logic [31:0]  cfg_wdata,
  input  logic         go,
  input  logic         stop,
  output logic         h_start,
  input  logic [4:0]   h_addr,
  input  logic         h_rq,
  output logic [31:0]  h_data,
  output logic         h_rdy,
  input  logic [255:0] h_hash,
  input  logic         h_done,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic [31:0]  found_nonce,
  output logic [31:0]  hash_count,
  output logic [1:0]   state_dbg
);

  sched_state_e state;

  logic [31:0]  hdr [0:HDR_WORDS-1];
  logic [31:0]  tgt [0:TGT_WORDS-1];
  logic [31:0]  nonce_end;
  logic [31:0]  nonce;
  logic         stop_pend;
  // Digest captured on h_done so CHECK does not depend on the hasher holding
  // h_hash after its completion pulse.
  logic [255:0] hash_q;

  logic [255:0] target;
  logic [255:0] hash_v;
  logic         hit;
  logic         at_end;

  assign target = {tgt[0], tgt[1], tgt[2], tgt[3], tgt[4], tgt[5], tgt[6], tgt[7]};
  assign hash_v = bswap256(hash_q);
  assign at_end = (nonce == nonce_end);
  assign state_dbg = state;

  sha256d_target_cmp u_cmp (
    .value  (hash_v),
    .target (target),
    .le     (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      for (int i = 0; i < HDR_WORDS; i++) hdr[i] <= '0;
      for (int i = 0; i < TGT_WORDS; i++) tgt[i] <= '0;
      nonce_end   <= '0;
      nonce       <= '0;
      stop_pend   <= 1'b0;
      hash_q      <= '0;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      found_nonce <= '0;
      hash_count  <= '0;
      h_start     <= 1'b0;
      h_rdy       <= 1'b0;
      h_data      <= '0;
    end else begin
      h_start <= 1'b0;
      h_rdy   <= 1'b0;

      // A stop can only abandon the job between hashes; remember it until
      // the next CHECK.
      if (stop && state != ST_IDLE) stop_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cfg_we) begin
            if (cfg_addr < 5'(HDR_WORDS))
              hdr[cfg_addr] <= cfg_wdata;
            else if (cfg_addr < 5'(NEND_ADDR))
              tgt[3'(cfg_addr - 5'(TGT_BASE))] <= cfg_wdata;
            else if (cfg_addr == 5'(NEND_ADDR))
              nonce_end <= cfg_wdata;
          end
          if (go) begin
            found      <= 1'b0;
            exhausted  <= 1'b0;
            hash_count <= '0;
            // A same-cycle write to the nonce word must be seen by go.
            nonce      <= (cfg_we && cfg_addr == 5'(NONCE_WORD)) ? cfg_wdata
                                                                  : hdr[NONCE_WORD];
            busy       <= 1'b1;
            h_start    <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          state <= ST_HASH;
        end

        ST_HASH: begin
          if (h_rq) begin
            h_rdy <= 1'b1;
            if (h_addr == 5'(NONCE_WORD))
              h_data <= nonce;
            else if (h_addr < 5'(HDR_WORDS))
              h_data <= hdr[h_addr];
            else
              h_data <= '0;
          end
          if (h_done) begin
            hash_q <= h_hash;
            state  <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (hash_count != '1) hash_count <= hash_count + 32'd1;
          if (hit) begin
            found       <= 1'b1;
            found_nonce <= nonce;
            busy        <= 1'b0;
            stop_pend   <= 1'b0;
            state       <= ST_IDLE;
          end else if (at_end || stop_pend || stop) begin
            exhausted <= at_end;
            busy      <= 1'b0;
            stop_pend <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            nonce   <= nonce + 32'd1;
            h_start <= 1'b1;
            state   <= ST_LAUNCH;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sha256d_nonce_scheduler
// Bench for sha256d_nonce_scheduler with a behavioural hasher of fixed
// 200-cycle latency. The hasher fetches all header words (plus one
// out-of-range address) over the request bus; every request pushes its
// expected answer to exp_q and the bus monitor pops and compares on h_rdy.
// The digest returned depends on the nonce actually served at word 19.
// ---------------------------------------------------------------------------
module tb_sha256d_nonce_scheduler;

  localparam int LAT = 200;

  localparam logic [255:0] GEN_TGT = 256'h00000000ffff0000000000000000000000000000000000000000000000000000;
  localparam logic [255:0] GEN_V   = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [31:0]  GEN_NONCE = 32'h7C2BAC1D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we, go, stop;
  logic [4:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic         h_start, h_rq, h_rdy, h_done;
  logic [4:0]   h_addr;
  logic [31:0]  h_data;
  logic [255:0] h_hash;
  logic         busy, found, exhausted;
  logic [31:0]  found_nonce, hash_count;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  hdr_model [0:19];
  logic [36:0]  exp_q [$];          // {addr, expected word}
  logic [31:0]  served_q [$];       // nonces observed at word 19
  logic [31:0]  last_nonce = '0;
  logic [31:0]  exp_start = '0;
  int           hash_idx = 0;
  int           done_count = 0;
  logic [31:0]  eq_nonce = 32'h5555_0000;
  logic [255:0] eq_v = '0;
  logic         rq_d;
  logic [36:0]  mon_ent;

  always #5 clk = ~clk;

  sha256d_nonce_scheduler #(.NONCE_WORD(19)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .go(go), .stop(stop),
    .h_start(h_start), .h_addr(h_addr), .h_rq(h_rq),
    .h_data(h_data), .h_rdy(h_rdy), .h_hash(h_hash), .h_done(h_done),
    .busy(busy), .found(found), .exhausted(exhausted),
    .found_nonce(found_nonce), .hash_count(hash_count),
    .state_dbg(state_dbg)
  );

  // Byte 0 (bits 7:0) becomes the most significant byte.
  function automatic logic [255:0] rev_bytes(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = x[8*i +: 8];
    return r;
  endfunction

  // Numeric hash value the model hasher produces for a given nonce.
  function automatic logic [255:0] model_v(input logic [31:0] n);
    if (n == GEN_NONCE) return GEN_V;
    if (n == eq_nonce) return eq_v;
    if (n == eq_nonce - 32'd1) return eq_v + 256'd1;
    return {n | 32'h8000_0000, 224'd1};
  endfunction

  // ---------------- behavioural hasher ----------------
  task automatic hasher_job();
    int cyc;
    logic [4:0] a;
    cyc = 0;
    for (int k = 0; k < 21; k++) begin
      a = (k == 20) ? 5'd25 : 5'(k);
      @(posedge clk); #1; cyc++;
      if (!rst_n) begin h_rq = 1'b0; return; end
      h_rq = 1'b1; h_addr = a;
      exp_q.push_back({a, (a == 5'd19) ? exp_start + 32'(hash_idx)
                                      : ((a < 5'd20) ? hdr_model[a] : 32'h0)});
      @(posedge clk); #1; cyc++;
      h_rq = 1'b0;
      if (!rst_n) return;
    end
    while (cyc < LAT - 1) begin
      @(posedge clk); #1; cyc++;
      if (!rst_n) return;
    end
    h_hash = rev_bytes(model_v(last_nonce));
    h_done = 1'b1;
    done_count++;
    hash_idx++;
    @(posedge clk); #1;
    h_done = 1'b0;
  endtask

  initial begin : hasher
    h_rq = 1'b0; h_addr = '0; h_done = 1'b0; h_hash = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && h_start === 1'b1) hasher_job();
    end
  end

  // ---------------- bus monitor / scoreboard ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rq_d <= 1'b0;
    else        rq_d <= h_rq;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (h_rdy === 1'b1 || rq_d === 1'b1)) begin
      n_checks++;
      if (h_rdy !== rq_d) begin
        n_fail++;
        $display("FAIL rdy_latency: h_rdy=%b required %b", h_rdy, rq_d);
      end
      if (rq_d === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bus_queue: response with no expected entry, h_data=%h", h_data);
        end else begin
          mon_ent = exp_q.pop_front();
          if (h_data !== mon_ent[31:0]) begin
            n_fail++;
            $display("FAIL bus_data: addr %0d h_data=%h required %h",
                     mon_ent[36:32], h_data, mon_ent[31:0]);
          end
          if (mon_ent[36:32] == 5'd19) begin
            served_q.push_back(h_data);
            last_nonce = h_data;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_job(input logic [31:0] start, input logic [31:0] nend,
                          input logic [255:0] tgt);
    for (int i = 0; i < 19; i++) cfg_write(5'(i), hdr_model[i]);
    cfg_write(5'd19, start);
    for (int i = 0; i < 8; i++) cfg_write(5'(20 + i), tgt[255-32*i -: 32]);
    cfg_write(5'd28, nend);
  endtask

  task automatic start_job(input logic [31:0] start);
    exp_start = start; hash_idx = 0; done_count = 0; served_q.delete();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    logic early;
    n = 0; early = 1'b0;
    do begin
      @(negedge clk); n++;
      if (busy === 1'b1 && (found === 1'b1 || exhausted === 1'b1)) early = 1'b1;
    end while (busy === 1'b1 && n < budget);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_result_timing: result flag seen while busy, required none", name);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, found, exhausted, h_start, h_rdy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: {busy,found,exh,h_start,h_rdy}=%b required 00000",
               {busy, found, exhausted, h_start, h_rdy});
    end
    n_checks++;
    if (found_nonce !== 32'h0 || hash_count !== 32'h0 || h_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_words: found_nonce=%h hash_count=%h h_data=%h required 0",
               found_nonce, hash_count, h_data);
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d required 0", state_dbg);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_genesis();
    load_job(32'h7C2BAC1A, 32'h7C2BAC1F, GEN_TGT);
    start_job(32'h7C2BAC1A);
    wait_idle(3000, "genesis");
    n_checks++;
    if (found !== 1'b1 || exhausted !== 1'b0) begin
      n_fail++;
      $display("FAIL genesis_flags: found=%b exhausted=%b required 1/0", found, exhausted);
    end
    n_checks++;
    if (found_nonce !== 32'h7C2BAC1D) begin
      n_fail++;
      $display("FAIL genesis_nonce: found_nonce=%h required 7c2bac1d", found_nonce);
    end
    n_checks++;
    if (hash_count !== 32'd4 || done_count != 4) begin
      n_fail++;
      $display("FAIL genesis_count: hash_count=%0d h_done=%0d required 4/4", hash_count, done_count);
    end
  endtask

  task automatic test_miss();
    logic [31:0] last;
    load_job(32'd5, 32'd9, 256'd0);
    start_job(32'd5);
    @(negedge clk);
    n_checks++;
    if (found !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_go_clears: found=%b busy=%b required 0/1", found, busy);
    end
    repeat (10) @(posedge clk);
    #1;
    cfg_write(5'd3, 32'hDEAD_BEEF);   // must be ignored while busy
    wait_idle(3000, "miss");
    n_checks++;
    if (exhausted !== 1'b1 || found !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_flags: exhausted=%b found=%b required 1/0", exhausted, found);
    end
    n_checks++;
    if (hash_count !== 32'd5) begin
      n_fail++;
      $display("FAIL miss_count: hash_count=%0d required 5", hash_count);
    end
    last = (served_q.size() > 0) ? served_q[served_q.size()-1] : 32'hX;
    n_checks++;
    if (served_q.size() != 5 || last !== 32'd9) begin
      n_fail++;
      $display("FAIL miss_last_nonce: served %0d nonces, last=%h required 5, 9",
               served_q.size(), last);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [4];
    exp_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    load_job(32'hFFFF_FFFE, 32'd1, 256'd0);
    start_job(32'hFFFF_FFFE);
    wait_idle(3000, "wrap");
    n_checks++;
    if (served_q.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_len: served %0d nonces required 4", served_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (served_q[i] !== exp_seq[i]) begin
          n_fail++;
          $display("FAIL wrap_seq[%0d]: nonce=%h required %h", i, served_q[i], exp_seq[i]);
        end
      end
    end
    n_checks++;
    if (exhausted !== 1'b1 || hash_count !== 32'd4) begin
      n_fail++;
      $display("FAIL wrap_end: exhausted=%b hash_count=%0d required 1/4", exhausted, hash_count);
    end
  endtask

  task automatic test_stop();
    int n;
    load_job(32'd100, 32'd199, 256'd0);
    start_job(32'd100);
    n = 0;
    while (done_count < 1 && n < 600) begin @(negedge clk); n++; end
    n_checks++;
    if (done_count != 1) begin
      n_fail++;
      $display("FAIL stop_first_hash: h_done count=%0d required 1", done_count);
    end
    repeat (20) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_idle(1000, "stop");
    n_checks++;
    if (done_count != 2 || hash_count !== 32'd2) begin
      n_fail++;
      $display("FAIL stop_count: h_done=%0d hash_count=%0d required 2/2", done_count, hash_count);
    end
    n_checks++;
    if (found !== 1'b0 || exhausted !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_flags: found=%b exhausted=%b required 0/0", found, exhausted);
    end
  endtask

  // V == target must hit (target+1 must not), the hit lands on nonce_end,
  // go shares its cycle with a write of the start nonce, and an idle stop
  // must not shorten the job.
  task automatic test_boundary();
    logic [255:0] bt;
    bt = {32'h0, 32'h0000_1234, 192'h5678};
    eq_nonce = 32'h20;
    eq_v = bt;
    load_job(32'h0000_1000, 32'h20, bt);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    exp_start = 32'h1E; hash_idx = 0; done_count = 0; served_q.delete();
    cfg_we = 1'b1; cfg_addr = 5'd19; cfg_wdata = 32'h1E; go = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; go = 1'b0;
    wait_idle(3000, "boundary");
    n_checks++;
    if (found !== 1'b1 || exhausted !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_flags: found=%b exhausted=%b required 1/0", found, exhausted);
    end
    n_checks++;
    if (found_nonce !== 32'h20 || hash_count !== 32'd3) begin
      n_fail++;
      $display("FAIL boundary_result: found_nonce=%h hash_count=%0d required 20/3",
               found_nonce, hash_count);
    end
    n_checks++;
    if (served_q.size() == 0 || served_q[0] !== 32'h1E) begin
      n_fail++;
      $display("FAIL boundary_go_write: first nonce %h required 1e",
               (served_q.size() > 0) ? served_q[0] : 32'hX);
    end
    eq_nonce = 32'h5555_0000;
  endtask

  task automatic test_async_reset();
    load_job(32'h40, 32'h50, 256'd0);
    start_job(32'h40);
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, found, exhausted, h_start, h_rdy} !== 5'b0) begin
      n_fail++;
      $display("FAIL areset_flags: {busy,found,exh,h_start,h_rdy}=%b required 00000",
               {busy, found, exhausted, h_start, h_rdy});
    end
    n_checks++;
    if (found_nonce !== 32'h0 || hash_count !== 32'h0 || h_data !== 32'h0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL areset_words: found_nonce=%h hash_count=%h h_data=%h state=%0d required 0",
               found_nonce, hash_count, h_data, state_dbg);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    load_job(32'h40, 32'h41, 256'd0);
    start_job(32'h40);
    wait_idle(2000, "areset_rerun");
    n_checks++;
    if (exhausted !== 1'b1 || found !== 1'b0 || hash_count !== 32'd2) begin
      n_fail++;
      $display("FAIL areset_rerun: exhausted=%b found=%b hash_count=%0d required 1/0/2",
               exhausted, found, hash_count);
    end
    n_checks++;
    if (served_q.size() != 2 || served_q[0] !== 32'h40 || served_q[1] !== 32'h41) begin
      n_fail++;
      $display("FAIL areset_nonces: served %0d nonces required 40,41", served_q.size());
    end
  endtask

  initial begin : main
    go = 1'b0; stop = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    hdr_model[0]  = 32'h01000000;
    for (int i = 1; i <= 8; i++) hdr_model[i] = 32'h0;
    hdr_model[9]  = 32'h3ba3edfd; hdr_model[10] = 32'h7a7b12b2;
    hdr_model[11] = 32'h7ac72c3e; hdr_model[12] = 32'h67768f61;
    hdr_model[13] = 32'h7fc81bc3; hdr_model[14] = 32'h888a5132;
    hdr_model[15] = 32'h3a9fb8aa; hdr_model[16] = 32'h4b1e5e4a;
    hdr_model[17] = 32'h29ab5f49; hdr_model[18] = 32'hffff001d;
    hdr_model[19] = 32'h0;

    test_reset();
    test_genesis();
    test_miss();
    test_wrap();
    test_stop();
    test_boundary();
    test_async_reset();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bus_leftover: %0d requests never answered, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
